pulse_seq_tx: RTL and testbench

PULSE_SEQ_TX -- requirements
Module: pulse_seq_tx

---
 rtl/pulse_seq_tx.sv | 370 +++++++++++++++++++++++++++++++++++++
 tb/tb_pulse_seq_tx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_seq_tx.sv
// -----------------------------------------------------------------------------
// pulse_seq_tx
//
// Programmable pulse-sequence transmitter. A small symbol memory holds 2-bit
// symbols (16 per 32-bit word). Each symbol selects an output level and one of
// two durations for that level. The sequencer plays symbols from PC 0 up to
// end_idx, optionally jumping back to loop_idx a programmable number of times,
// then returns to idle and raises a sticky done flag.
//
// Optional feature: define PULSE_SEQ_CARRIER_EN to build a carrier generator
// that can gate the high level of each symbol. Without the macro no carrier
// logic is built and its register fields read back as 0.
//
// Ports:
//   clk       in   1   clock
//   rst_n     in   1   synchronous active-low reset
//   wr_en     in   1   register/memory write strobe
//   wr_addr   in   6   write address (0..5 registers, 32+k memory word k)
//   wr_data   in   32  write data
//   rd_addr   in   6   read address
//   rd_data   out  32  combinational read data (0 for unmapped addresses)
//   irq_clr   in   1   clears done_irq (a simultaneous set wins)
//   busy      out  1   sequence active (FETCH or RUN)
//   done_irq  out  1   sticky sequence-complete flag
//   tx_out    out  1   pulse output
// -----------------------------------------------------------------------------
module pulse_seq_tx #(
   parameter int DEPTH_WORDS = 8,
   parameter int DUR_W       = 16,
   parameter int PRESC_W     = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [5:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic [5:0]  rd_addr,
   output logic [31:0] rd_data,
   input  logic        irq_clr,
   output logic        busy,
   output logic        done_irq,
   output logic        tx_out
);

   localparam int PC_W      = $clog2(DEPTH_WORDS * 16);
   localparam int WI_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int SHIFT_MAX = (1 << PRESC_W) - 1;
   // Counter holds (D+1)*2^presc - 1, which needs DUR_W + max shift bits.
   localparam int CNT_W     = DUR_W + SHIFT_MAX;

   localparam logic [5:0] A_CTRL   = 6'd0;
   localparam logic [5:0] A_PROG   = 6'd1;
   localparam logic [5:0] A_DUR_L  = 6'd2;
   localparam logic [5:0] A_DUR_H  = 6'd3;
   localparam logic [5:0] A_TIMING = 6'd4;
   localparam logic [5:0] A_STATUS = 6'd5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   // ---------------------------------------------------------------- config
   logic               idle_level_q;
   logic               invert_q;
   logic [7:0]         end_idx_q;
   logic [7:0]         loop_idx_q;
   logic [15:0]        loop_cnt_q;
   logic [DUR_W-1:0]   low_a_q;
   logic [DUR_W-1:0]   low_b_q;
   logic [DUR_W-1:0]   high_a_q;
   logic [DUR_W-1:0]   high_b_q;
   logic [PRESC_W-1:0] presc_q;
   logic [31:0]        mem_q [DEPTH_WORDS];

   // ------------------------------------------------------------- sequencer
   state_t             state_q;
   logic               busy_q;
   logic               done_q;
   logic [PC_W-1:0]    pc_q;
   logic [15:0]        loops_q;
   logic [1:0]         sym_q;
   logic [CNT_W-1:0]   cnt_q;
   // Output-shaping settings captured at each symbol load, so a config write
   // during a sequence only changes the output from the next symbol on.
   logic               idle_act_q;
   logic               inv_act_q;

`ifdef PULSE_SEQ_CARRIER_EN
   logic               carrier_en_q;
   logic [15:0]        carrier_half_q;
   logic               car_en_act_q;
   logic [15:0]        car_half_act_q;
   logic [15:0]        car_cnt_q;
   logic               car_q;
`endif

   // ---------------------------------------------------------- write decode
   logic            ctrl_wr;
   logic            start_req;
   logic            stop_req;
   logic            mem_wr;
   logic [WI_W-1:0] wr_word;

   assign ctrl_wr   = wr_en && (wr_addr == A_CTRL);
   assign start_req = ctrl_wr && wr_data[0];
   assign stop_req  = ctrl_wr && wr_data[1];
   assign mem_wr    = wr_en && wr_addr[5] && (int'(wr_addr[4:0]) < DEPTH_WORDS);
   assign wr_word   = WI_W'(wr_addr[4:0]);

   // --------------------------------------------------- next-PC and prefetch
   logic            at_end_d;
   logic            seq_last_d;
   logic            sym_done_d;
   logic            act_load_d;
   logic [PC_W-1:0] pc_adv_d;
   logic [PC_W-1:0] fetch_pc_d;
   logic [WI_W-1:0] fetch_widx_d;
   logic [31:0]     fetch_word_d;
   logic [1:0]      fetch_sym_d;
   logic [CNT_W-1:0] fetch_cnt_d;

   always_comb begin
      at_end_d   = (pc_q == end_idx_q[PC_W-1:0]);
      seq_last_d = at_end_d && (loops_q == 16'd0);
      sym_done_d = (state_q == S_RUN) && (cnt_q == '0);
      // PC + 1 wraps naturally at the top of the PC range.
      pc_adv_d   = at_end_d ? loop_idx_q[PC_W-1:0] : pc_q + PC_W'(1);
      // FETCH reads the current PC; in RUN the single read port looks ahead
      // at the next PC so the following symbol loads with no gap.
      fetch_pc_d = (state_q == S_FETCH) ? pc_q : pc_adv_d;
      act_load_d = (state_q == S_FETCH) || (sym_done_d && !seq_last_d);
   end

   generate
      if (DEPTH_WORDS > 1) begin : g_widx
         assign fetch_widx_d = fetch_pc_d[PC_W-1:4];
      end else begin : g_widx1
         assign fetch_widx_d = '0;
      end
   endgenerate

   always_comb begin
      logic [DUR_W-1:0] dur;
      logic [CNT_W:0]   len;
      fetch_word_d = mem_q[fetch_widx_d];
      fetch_sym_d  = fetch_word_d[{fetch_pc_d[3:0], 1'b0} +: 2];
      // Level in bit 1, duration b/a select in bit 0.
      case (fetch_sym_d)
         2'b00:   dur = low_a_q;
         2'b01:   dur = low_b_q;
         2'b10:   dur = high_a_q;
         default: dur = high_b_q;
      endcase
      len         = ((CNT_W + 1)'(dur) + (CNT_W + 1)'(1)) << presc_q;
      fetch_cnt_d = CNT_W'(len - (CNT_W + 1)'(1));
   end

   // -------------------------------------------------------- config writes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idle_level_q   <= 1'b0;
         invert_q       <= 1'b0;
         end_idx_q      <= '0;
         loop_idx_q     <= '0;
         loop_cnt_q     <= '0;
         low_a_q        <= '0;
         low_b_q        <= '0;
         high_a_q       <= '0;
         high_b_q       <= '0;
         presc_q        <= '0;
`ifdef PULSE_SEQ_CARRIER_EN
         carrier_en_q   <= 1'b0;
         carrier_half_q <= '0;
`endif
      end else if (wr_en) begin
         case (wr_addr)
            A_CTRL: begin
               idle_level_q <= wr_data[2];
               invert_q     <= wr_data[3];
`ifdef PULSE_SEQ_CARRIER_EN
               carrier_en_q <= wr_data[4];
`endif
            end
            A_PROG: begin
               end_idx_q  <= wr_data[7:0];
               loop_idx_q <= wr_data[15:8];
               loop_cnt_q <= wr_data[31:16];
            end
            A_DUR_L: begin
               low_a_q <= wr_data[DUR_W-1:0];
               low_b_q <= wr_data[16 +: DUR_W];
            end
            A_DUR_H: begin
               high_a_q <= wr_data[DUR_W-1:0];
               high_b_q <= wr_data[16 +: DUR_W];
            end
            A_TIMING: begin
               presc_q <= wr_data[PRESC_W-1:0];
`ifdef PULSE_SEQ_CARRIER_EN
               carrier_half_q <= wr_data[31:16];
`endif
            end
            default: ;
         endcase
      end
   end

   // Symbol memory has no reset; writes are accepted even mid-sequence.
   always_ff @(posedge clk) begin
      if (mem_wr) begin
         mem_q[wr_word] <= wr_data;
      end
   end

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pc_q       <= '0;
         loops_q    <= '0;
         sym_q      <= '0;
         cnt_q      <= '0;
         idle_act_q <= 1'b0;
         inv_act_q  <= 1'b0;
`ifdef PULSE_SEQ_CARRIER_EN
         car_en_act_q   <= 1'b0;
         car_half_act_q <= '0;
         car_cnt_q      <= '0;
         car_q          <= 1'b0;
`endif
      end else begin
         // Clear first so that a completion in this same cycle overrides it.
         if (irq_clr) begin
            done_q <= 1'b0;
         end

         case (state_q)
            S_IDLE: begin
               if (start_req) begin
                  state_q <= S_FETCH;
                  busy_q  <= 1'b1;
                  pc_q    <= '0;
                  loops_q <= loop_cnt_q;
               end
            end
            S_FETCH: begin
               sym_q   <= fetch_sym_d;
               cnt_q   <= fetch_cnt_d;
               state_q <= S_RUN;
`ifdef PULSE_SEQ_CARRIER_EN
               car_cnt_q <= '0;
               car_q     <= 1'b0;
`endif
            end
            S_RUN: begin
`ifdef PULSE_SEQ_CARRIER_EN
               if (car_cnt_q == car_half_act_q) begin
                  car_cnt_q <= '0;
                  car_q     <= ~car_q;
               end else begin
                  car_cnt_q <= car_cnt_q + 16'd1;
               end
`endif
               if (cnt_q == '0) begin
                  if (seq_last_d) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     if (!stop_req) begin
                        done_q <= 1'b1;
                     end
                  end else begin
                     pc_q  <= pc_adv_d;
                     sym_q <= fetch_sym_d;
                     cnt_q <= fetch_cnt_d;
                     if (at_end_d) begin
                        loops_q <= loops_q - 16'd1;
                     end
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase

         if (act_load_d) begin
            idle_act_q <= idle_level_q;
            inv_act_q  <= invert_q;
`ifdef PULSE_SEQ_CARRIER_EN
            car_en_act_q   <= carrier_en_q;
            car_half_act_q <= carrier_half_q;
`endif
         end

         // Stop overrides everything above, including a start or a completion.
         if (stop_req) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end
      end
   end

   // --------------------------------------------------------------- output
   logic mod_level_d;
   logic car_en_rd;
   logic [15:0] car_half_rd;

`ifdef PULSE_SEQ_CARRIER_EN
   assign mod_level_d = car_en_act_q ? (sym_q[1] & car_q) : sym_q[1];
   assign car_en_rd   = carrier_en_q;
   assign car_half_rd = carrier_half_q;
`else
   assign mod_level_d = sym_q[1];
   assign car_en_rd   = 1'b0;
   assign car_half_rd = 16'd0;
`endif

   always_comb begin
      if (state_q == S_RUN) begin
         tx_out = mod_level_d ^ inv_act_q;
      end else begin
         // IDLE and FETCH both drive the idle level.
         tx_out = idle_level_q ^ invert_q;
      end
   end

   assign busy     = busy_q;
   assign done_irq = done_q;

   // ------------------------------------------------------------ read mux
   logic            rd_mem_hit;
   logic [WI_W-1:0] rd_word;

   assign rd_mem_hit = rd_addr[5] && (int'(rd_addr[4:0]) < DEPTH_WORDS);
   assign rd_word    = WI_W'(rd_addr[4:0]);

   always_comb begin
      rd_data = '0;
      case (rd_addr)
         A_CTRL:   rd_data = {27'd0, car_en_rd, invert_q, idle_level_q, 2'b00};
         A_PROG:   rd_data = {loop_cnt_q, loop_idx_q, end_idx_q};
         A_DUR_L: begin
            rd_data[DUR_W-1:0]  = low_a_q;
            rd_data[16 +: DUR_W] = low_b_q;
         end
         A_DUR_H: begin
            rd_data[DUR_W-1:0]  = high_a_q;
            rd_data[16 +: DUR_W] = high_b_q;
         end
         A_TIMING: begin
            rd_data[PRESC_W-1:0] = presc_q;
            rd_data[31:16]       = car_half_rd;
         end
         A_STATUS: rd_data = {loops_q, 8'(pc_q), 6'd0, done_q, busy_q};
         default: begin
            if (rd_mem_hit) begin
               rd_data = mem_q[rd_word];
            end
         end
      endcase
   end

endmodule

// File: tb/tb_pulse_seq_tx.sv
// -----------------------------------------------------------------------------
// tb_pulse_seq_tx
//
// Self-checking bench for pulse_seq_tx (default parameters). The expected
// output waveform of each sequence is produced by unrolling the program into a
// per-cycle list of (tx level, PC, loops remaining) and compared cycle by
// cycle. Define PULSE_SEQ_CARRIER_EN for both files to cover the carrier.
// -----------------------------------------------------------------------------
module tb_pulse_seq_tx;

   localparam logic [5:0] A_CTRL   = 6'd0;
   localparam logic [5:0] A_PROG   = 6'd1;
   localparam logic [5:0] A_DUR_L  = 6'd2;
   localparam logic [5:0] A_DUR_H  = 6'd3;
   localparam logic [5:0] A_TIMING = 6'd4;
   localparam logic [5:0] A_STATUS = 6'd5;
   localparam int         NPC      = 128;
`ifdef PULSE_SEQ_CARRIER_EN
   localparam bit CAR_BUILD = 1'b1;
`else
   localparam bit CAR_BUILD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;
   logic [5:0]  rd_addr;
   logic [31:0] rd_data;
   logic        irq_clr;
   logic        busy;
   logic        done_irq;
   logic        tx_out;

   int checks = 0;
   int errors = 0;

   // Configuration as the bench intends it.
   int          m_end, m_loop, m_loop_cnt;
   int          m_la, m_lb, m_ha, m_hb, m_presc, m_car_half;
   bit          m_idle, m_inv, m_car_en;
   logic [31:0] m_mem [8];

   bit exp_tx [$];
   int exp_pc [$];
   int exp_lp [$];

   pulse_seq_tx dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .irq_clr  (irq_clr),
      .busy     (busy),
      .done_irq (done_irq),
      .tx_out   (tx_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [5:0] a, output logic [31:0] d);
      rd_addr = a;
      #1;
      d = rd_data;
   endtask

   function automatic logic [31:0] ctrl_bits(input logic [1:0] cmd);
      return {27'd0, m_car_en, m_inv, m_idle, cmd};
   endfunction

   task automatic cfg_write();
      wr(A_CTRL, ctrl_bits(2'b00));
      wr(A_PROG, {16'(m_loop_cnt), 8'(m_loop), 8'(m_end)});
      wr(A_DUR_L, {16'(m_lb), 16'(m_la)});
      wr(A_DUR_H, {16'(m_hb), 16'(m_ha)});
      wr(A_TIMING, {16'(m_car_half), 12'd0, 4'(m_presc)});
      for (int i = 0; i < 8; i++) wr(6'(32 + i), m_mem[i]);
   endtask

   // Unroll the program: each symbol contributes (D+1)*2^presc cycles.
   task automatic build_model();
      int pc, lp, d, n, t;
      bit lvl, car, con;
      logic [1:0] s;
      exp_tx.delete(); exp_pc.delete(); exp_lp.delete();
      pc = 0; lp = m_loop_cnt; t = 0;
      con = CAR_BUILD && m_car_en;
      while (exp_tx.size() < 5000) begin
         s   = 2'((m_mem[pc / 16] >> (2 * (pc % 16))) & 32'd3);
         lvl = s[1];
         if (lvl) d = s[0] ? m_hb : m_ha;
         else     d = s[0] ? m_lb : m_la;
         n = (d + 1) << m_presc;
         for (int i = 0; i < n; i++) begin
            car = ((t / (m_car_half + 1)) % 2) == 1;
            exp_tx.push_back((con ? (lvl & car) : lvl) ^ m_inv);
            exp_pc.push_back(pc);
            exp_lp.push_back(lp);
            t++;
         end
         if (pc == (m_end % NPC)) begin
            if (lp == 0) break;
            pc = m_loop % NPC;
            lp--;
         end else begin
            pc = (pc + 1) % NPC;
         end
      end
   endtask

   // Start the programmed sequence and follow it cycle by cycle.
   // stop_at/start_at: cycle index at which to write stop / a redundant start.
   task automatic run_seq(input string name, input int stop_at, input int start_at,
                          input bit clr_at_end);
      int last;
      bit stopped;
      logic [31:0] ctrl;
      build_model();
      last = exp_tx.size() - 1;
      ctrl = ctrl_bits(2'b01);
      $display("run %s: %0d cycles", name, exp_tx.size());
      @(negedge clk); irq_clr = 1'b1;
      @(negedge clk); irq_clr = 1'b0;
      chk({name, "_pre_done"}, 32'(done_irq), 32'd0);
      rd_addr = A_STATUS;
      wr(A_CTRL, ctrl);
      chk({name, "_fetch_busy"}, 32'(busy), 32'd1);
      chk({name, "_fetch_tx"}, 32'(tx_out), 32'(m_idle ^ m_inv));
      chk({name, "_fetch_pc"}, 32'(rd_data[15:8]), 32'd0);
      chk({name, "_fetch_loops"}, 32'(rd_data[31:16]), 32'(m_loop_cnt));
      stopped = 1'b0;
      for (int k = 0; k <= last; k++) begin
         @(negedge clk);
         wr_en = 1'b0; irq_clr = 1'b0;
         chk($sformatf("%s_tx@%0d", name, k), 32'(tx_out), 32'(exp_tx[k]));
         chk($sformatf("%s_busy@%0d", name, k), 32'(busy), 32'd1);
         chk($sformatf("%s_pc@%0d", name, k), 32'(rd_data[15:8]), 32'(exp_pc[k]));
         chk($sformatf("%s_loops@%0d", name, k), 32'(rd_data[31:16]), 32'(exp_lp[k]));
         chk($sformatf("%s_done@%0d", name, k), 32'(done_irq), 32'd0);
         if (k == stop_at) begin
            wr_en = 1'b1; wr_addr = A_CTRL; wr_data = ctrl_bits(2'b10);
            stopped = 1'b1;
            break;
         end
         if (k == start_at) begin
            wr_en = 1'b1; wr_addr = A_CTRL; wr_data = ctrl;
         end
         if (clr_at_end && k == last) irq_clr = 1'b1;
      end
      @(negedge clk);
      wr_en = 1'b0; irq_clr = 1'b0;
      chk({name, "_end_busy"}, 32'(busy), 32'd0);
      chk({name, "_end_tx"}, 32'(tx_out), 32'(m_idle ^ m_inv));
      chk({name, "_end_done"}, 32'(done_irq), stopped ? 32'd0 : 32'd1);
   endtask

   task automatic cfg_clear();
      m_end = 0; m_loop = 0; m_loop_cnt = 0;
      m_la = 0; m_lb = 0; m_ha = 0; m_hb = 0; m_presc = 0; m_car_half = 0;
      m_idle = 0; m_inv = 0; m_car_en = 0;
      for (int i = 0; i < 8; i++) m_mem[i] = 32'd0;
   endtask

   initial begin
      logic [31:0] v;
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr = '0; irq_clr = 1'b0;
      cfg_clear();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state.
      chk("rst_tx", 32'(tx_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done_irq), 32'd0);
      for (int a = 0; a <= 6; a++) begin
         rd(6'(a), v);
         chk($sformatf("rst_reg%0d", a), v, 32'd0);
      end

      // Register readback and unmapped addresses.
      wr(A_CTRL, 32'h0000_001C);
      rd(A_CTRL, v);   chk("rb_ctrl", v, CAR_BUILD ? 32'h1C : 32'h0C);
      wr(A_PROG, 32'hABCD_1203);
      rd(A_PROG, v);   chk("rb_prog", v, 32'hABCD_1203);
      wr(A_DUR_L, 32'h1234_5678);
      rd(A_DUR_L, v);  chk("rb_dur_l", v, 32'h1234_5678);
      wr(A_DUR_H, 32'h9ABC_DEF0);
      rd(A_DUR_H, v);  chk("rb_dur_h", v, 32'h9ABC_DEF0);
      wr(A_TIMING, 32'h0005_000A);
      rd(A_TIMING, v); chk("rb_timing", v, CAR_BUILD ? 32'h0005_000A : 32'h0000_000A);
      wr(6'd35, 32'hDEAD_BEEF);
      rd(6'd35, v);    chk("rb_mem3", v, 32'hDEAD_BEEF);
      wr(6'd6, 32'hFFFF_FFFF);
      rd(6'd6, v);     chk("rb_unmapped6", v, 32'd0);
      wr(6'd40, 32'hFFFF_FFFF);
      rd(6'd40, v);    chk("rb_unmapped40", v, 32'd0);
      rd(A_STATUS, v); chk("rb_status_idle", v, 32'd0);

      // Two-symbol program played once.
      cfg_clear();
      m_mem[0] = 32'h0000_000E; m_end = 1; m_la = 2; m_hb = 4;
      cfg_write();
      run_seq("basic", -1, -1, 1'b0);

      // Loop back onto the last symbol twice.
      cfg_clear();
      m_mem[0] = 32'h0000_000B; m_end = 1; m_loop = 1; m_loop_cnt = 2;
      m_la = 1; m_lb = 2; m_ha = 3; m_hb = 0;
      cfg_write();
      run_seq("loop", -1, -1, 1'b0);

      // Prescaler: every symbol lasts 16 cycles.
      cfg_clear();
      m_mem[0] = 32'h0000_00D8; m_end = 3; m_presc = 3;
      m_la = 1; m_lb = 1; m_ha = 1; m_hb = 1;
      cfg_write();
      run_seq("presc", -1, -1, 1'b0);

      // Stop mid-run, with invert set.
      cfg_clear();
      m_mem[0] = 32'h0000_0072; m_end = 3; m_presc = 1; m_idle = 1; m_inv = 1;
      m_la = 3; m_lb = 3; m_ha = 3; m_hb = 3;
      cfg_write();
      run_seq("stop", 10, -1, 1'b0);

      // Start and stop in one write: stop wins.
      wr(A_CTRL, ctrl_bits(2'b11));
      chk("startstop_busy", 32'(busy), 32'd0);
      chk("startstop_done", 32'(done_irq), 32'd0);

      // Redundant start while busy, and irq_clr colliding with completion.
      run_seq("restart", -1, 9, 1'b1);
      @(negedge clk); irq_clr = 1'b1;
      @(negedge clk); irq_clr = 1'b0;
      chk("irq_clr_done", 32'(done_irq), 32'd0);

      // Idle output with invert only.
      cfg_clear();
      m_inv = 1;
      wr(A_CTRL, ctrl_bits(2'b00));
      chk("idle_inv_tx", 32'(tx_out), 32'd1);

      // Loop target near the top of memory: PC wraps 127 -> 0.
      cfg_clear();
      for (int i = 0; i < 8; i++) m_mem[i] = $urandom;
      m_end = 1; m_loop = 126; m_loop_cnt = 1;
      m_la = 1; m_lb = 0; m_ha = 2; m_hb = 1;
      cfg_write();
      run_seq("wrap", -1, -1, 1'b0);

      // Randomised programs.
      for (int r = 0; r < 6; r++) begin
         cfg_clear();
         for (int i = 0; i < 8; i++) m_mem[i] = $urandom;
         m_end = $urandom_range(0, 5);
         m_loop = $urandom_range(0, m_end);
         m_loop_cnt = $urandom_range(0, 2);
         m_la = $urandom_range(0, 3); m_lb = $urandom_range(0, 3);
         m_ha = $urandom_range(0, 3); m_hb = $urandom_range(0, 3);
         m_presc = $urandom_range(0, 2);
         m_idle = 1'($urandom_range(0, 1)); m_inv = 1'($urandom_range(0, 1));
         cfg_write();
         run_seq($sformatf("rand%0d", r), -1, -1, 1'b0);
      end

`ifdef PULSE_SEQ_CARRIER_EN
      // Carrier gating a long high symbol.
      cfg_clear();
      m_mem[0] = 32'h0000_0003; m_end = 0; m_hb = 9; m_car_en = 1; m_car_half = 1;
      cfg_write();
      run_seq("carrier", -1, -1, 1'b0);
`endif

      // Reset mid-sequence aborts with no done flag.
      cfg_clear();
      m_mem[0] = 32'h0000_00AA; m_end = 3; m_presc = 2; m_inv = 1;
      m_ha = 3; m_hb = 3;
      cfg_write();
      wr(A_CTRL, ctrl_bits(2'b01));
      repeat (4) @(negedge clk);
      chk("midrst_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done_irq), 32'd0);
      chk("midrst_tx", 32'(tx_out), 32'd0);
      rd(A_STATUS, v);
      chk("midrst_status", v, 32'd0);
      repeat (20) @(negedge clk);
      chk("midrst_done_later", 32'(done_irq), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
